// File: rtl/game_sfx_player.sv
// Sound-effect sequencer: plays a 4-note square-wave tune per one-hot request.
// Optional SFX_QUEUE_EN adds a 1-deep pending slot for non-preempting requests.
module game_sfx_player #(
  parameter int unsigned HALF_BASE = 25000,
  parameter int unsigned NOTE_CYC  = 4000000
) (
  input  logic        apb_pclk,
  input  logic        apb_prstn,
  input  logic [12:0] audio,
  input  logic        audio_enable,
  input  logic        mute,
  output logic        buzzer,
  output logic        busy,
  output logic [3:0]  cur_sfx,
  output logic        sfx_done,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DurW  = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam int unsigned HalfW = $clog2(7 * HALF_BASE + 1);

  typedef enum logic {StIdle, StPlay} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cur_q, cur_d;
  logic [1:0]         note_q, note_d;
  logic [DurW-1:0]    dur_q, dur_d;
  logic [HalfW-1:0]   half_q, half_d;
  logic               buz_q, buz_d;
  logic               done_q, done_d;
  logic [7:0]         drop_q, drop_d;
`ifdef SFX_QUEUE_EN
  logic               pend_vld_q, pend_vld_d;
  logic [3:0]         pend_k_q, pend_k_d;
`endif

  logic               req_vld;
  logic [3:0]         req_k;
  logic               start;
  logic [3:0]         start_k;
  logic               drop_inc;
  logic               note_end;
  logic [2:0]         cur_code, nxt_code, start_code;

  function automatic logic [2:0] note_code(input logic [3:0] k, input logic [1:0] n);
    int unsigned kk;
    kk = 32'(k);
    case (n)
      2'd0:    return 3'((kk % 7) + 1);
      2'd1:    return 3'(((kk + 2) % 7) + 1);
      2'd2:    return 3'(((kk + 4) % 7) + 1);
      default: return 3'd0;
    endcase
  endfunction

  // Counter reload value; meaningless for the rest code, where the buzzer stays low.
  function automatic logic [HalfW-1:0] half_reload(input logic [2:0] c);
    return HalfW'(HALF_BASE * (8 - 32'(c)) - 1);
  endfunction

  assign req_vld = audio_enable & (|audio);

  // Lowest set bit wins on multi-hot codes.
  always_comb begin
    req_k = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (audio[i]) req_k = 4'(i);
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state_q    <= StIdle;
      cur_q      <= 4'hF;
      note_q     <= 2'd0;
      dur_q      <= '0;
      half_q     <= '0;
      buz_q      <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 8'd0;
`ifdef SFX_QUEUE_EN
      pend_vld_q <= 1'b0;
      pend_k_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      half_q     <= half_d;
      buz_q      <= buz_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
`ifdef SFX_QUEUE_EN
      pend_vld_q <= pend_vld_d;
      pend_k_q   <= pend_k_d;
`endif
    end
  end

  assign note_end   = (dur_q == DurW'(NOTE_CYC - 1));
  assign cur_code   = note_code(cur_q, note_q);
  assign nxt_code   = note_code(cur_q, note_q + 2'd1);
  assign start_code = note_code(start_k, 2'd0);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    note_d   = note_q;
    dur_d    = dur_q;
    half_d   = half_q;
    buz_d    = buz_q;
    done_d   = 1'b0;
    start    = 1'b0;
    start_k  = req_k;
    drop_inc = 1'b0;
`ifdef SFX_QUEUE_EN
    pend_vld_d = pend_vld_q;
    pend_k_d   = pend_k_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_vld) start = 1'b1;
      end
      StPlay: begin
        // A request on the very last cycle always wins over natural completion.
        if (req_vld && ((req_k <= cur_q) || (note_end && (note_q == 2'd3)))) begin
          start = 1'b1;
        end else begin
          if (req_vld) begin
`ifdef SFX_QUEUE_EN
            drop_inc   = pend_vld_q;
            pend_vld_d = 1'b1;
            pend_k_d   = req_k;
`else
            drop_inc   = 1'b1;
`endif
          end
          if (note_end && (note_q == 2'd3)) begin
            done_d  = 1'b1;
            state_d = StIdle;
            cur_d   = 4'hF;
            note_d  = 2'd0;
            dur_d   = '0;
            half_d  = '0;
            buz_d   = 1'b0;
`ifdef SFX_QUEUE_EN
            if (pend_vld_q) begin
              start      = 1'b1;
              start_k    = pend_k_q;
              pend_vld_d = 1'b0;
            end
`endif
          end else if (note_end) begin
            note_d = note_q + 2'd1;
            dur_d  = '0;
            half_d = half_reload(nxt_code);
            buz_d  = (nxt_code != 3'd0);
          end else begin
            dur_d = dur_q + DurW'(1);
            if (half_q == '0) begin
              half_d = half_reload(cur_code);
              buz_d  = (cur_code != 3'd0) ? ~buz_q : 1'b0;
            end else begin
              half_d = half_q - HalfW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StPlay;
      cur_d   = start_k;
      note_d  = 2'd0;
      dur_d   = '0;
      half_d  = half_reload(start_code);
      buz_d   = (start_code != 3'd0);
    end
    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    buzzer   = buz_q & ~mute;
    busy     = (state_q == StPlay);
    cur_sfx  = cur_q;
    sfx_done = done_q;
    drop_cnt = drop_q;
  end

endmodule
